mult_div_unit: RTL and testbench
================================

Name: mult_div_unit

Overview:
Iterative multiply/divide unit that feeds the datapath's HI/LO register (the hilo_d input) for MULT, MULTU, DIV and DIVU.
- Replaces the single-cycle combinational multiply path, so the processor can close timing at higher clock rates.
- The controller stalls the PC while busy is high, and writes HI/LO (we_hilo) on done.
- Radix-2: one bit per cycle, shift-add for multiply, restoring algorithm for divide.

Parameters:
- WIDTH, 32, operand width; hi and lo are each WIDTH bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- op  input  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV
- a  input  WIDTH  multiplicand / dividend (rs)
- b  input  WIDTH  multiplier / divisor (rt)
- busy  output  1  high in CALC
- done  output  1  one-cycle pulse when hi/lo are valid
- hi  output  WIDTH  product upper half / remainder
- lo  output  WIDTH  product lower half / quotient
- div_by_zero  output  1  high with done when a divide had b==0

Behaviour:
- Reset (synchronous, active-high): state=IDLE; busy=0, done=0, div_by_zero=0, hi=0, lo=0. Reset during CALC aborts the operation; the next cycle shows IDLE with all outputs 0.
- States and transitions:
  - IDLE -> CALC when start=1 (edge E0). Operands and op are latched; signed ops store |a| and |b| and record the result sign.
  - CALC: one iteration per edge. After the iteration at edge E_WIDTH, go to DONE and register sign-corrected hi/lo at that same edge.
  - DONE: done=1 for exactly one cycle. Next edge goes to IDLE; a start in DONE is ignored.
- Latency: done is high in the cycle after E_WIDTH, i.e. WIDTH cycles after the cycle in which start was sampled. busy=1 in the cycles following E0 through E_WIDTH.
- Stability:
  - start, op, a, b are ignored while busy or done.
  - hi/lo hold their value from done until the next accepted start completes. Intermediate values are never exposed on hi/lo.
- Multiply:
  - 2*WIDTH-bit product; hi = upper bits, lo = lower bits.
  - MULT gives the two's-complement signed product.
- Divide:
  - lo = quotient truncated toward zero; hi = remainder, whose sign follows the dividend.
  - DIV of most-negative / -1: lo = 0x80000000, hi = 0 (for WIDTH=32). No trap.
  - b==0 (DIV or DIVU): skip iterations; CALC -> DONE at E1. Result: lo = all ones, hi = a, div_by_zero=1 during done.
- div_by_zero is cleared at the next accepted start.

Optional Feature:
- Macro: MDU_EARLY_TERM_EN.
- Defined:
  - Multiply terminates once the remaining shifted |b| register is zero.
  - Iterations = max(1, bit-length of |b|); b=0 completes after 1 iteration, b=5 after 3.
  - Divide latency is unchanged.
- Undefined: every non-zero-divisor operation takes exactly WIDTH iterations.

Decomposition:
- Shared package mdu_pkg:
  - op encodings: OP_MULTU, OP_MULT, OP_DIVU, OP_DIV
  - state encodings: S_IDLE, S_CALC, S_DONE
  - default WIDTH constant
- One natural sub-module: mdu_sign_fix. Combinational; negates the product or quotient/remainder per the recorded signs and op.
- The FSM, counter and shift registers stay in mult_div_unit.

Test Plan:
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; done exactly 32 cycles after the start cycle; busy low during done.
- MULT a=0xFFFFFFFD (-3), b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. MULTU with the same operands -> hi=0x00000004, lo=0xFFFFFFF1.
- DIVU a=100, b=7 -> lo=14, hi=2. DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIV a=0x1234, b=0 -> done at the cycle after E1, div_by_zero=1, lo=0xFFFFFFFF, hi=0x1234. A following MULTU 2*3 -> div_by_zero=0, lo=6.
- Start MULTU 2*3; pulse start with a=9, b=9 at iteration 5 -> ignored, result lo=6. New start; assert rst at iteration 10 -> next cycle busy=0, done=0, hi=lo=0, and no done pulse follows.
- With MDU_EARLY_TERM_EN: MULTU a=7, b=5 -> lo=35 and done 3 cycles after start. Without it: same result, done after 32 cycles.

Source files
------------

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared op/state encodings and default operand width for the multiply/divide unit.
package mdu_pkg;
    localparam int WIDTH_DEF = 32;
    typedef enum logic [1:0] {
        OP_MULTU = 2'b00,
        OP_MULT  = 2'b01,
        OP_DIVU  = 2'b10,
        OP_DIV   = 2'b11
    } op_e;
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_DONE = 2'b10
    } state_e;
endpackage

// File: rtl/mdu_sign_fix.sv
// mdu_sign_fix: applies recorded result signs to an unsigned product or quotient/remainder pair.
module mdu_sign_fix
    import mdu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             is_div_i,
    input  logic             neg_pq_i,
    input  logic             neg_r_i,
    input  logic [WIDTH-1:0] hi_i,
    input  logic [WIDTH-1:0] lo_i,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);
    logic [2*WIDTH-1:0] prod, prod_n;
    assign prod   = {hi_i, lo_i};
    assign prod_n = neg_pq_i ? -prod : prod;
    assign hi_o   = is_div_i ? (neg_r_i ? -hi_i : hi_i) : prod_n[2*WIDTH-1:WIDTH];
    assign lo_o   = is_div_i ? (neg_pq_i ? -lo_i : lo_i) : prod_n[WIDTH-1:0];
endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: radix-2 iterative MULT/MULTU/DIV/DIVU feeding HI/LO.
// Defining MDU_EARLY_TERM_EN lets multiplies stop once the remaining multiplier bits are zero.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);
    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d, mc_q, mc_d, acc_m;
    logic [WIDTH-1:0]   mp_q, mp_d, hi_q, hi_d, lo_q, lo_d;
    logic               is_div_q, is_div_d, sgn_p_q, sgn_p_d, sgn_r_q, sgn_r_d;
    logic               bz_q, bz_d, dz_q, dz_d;
    logic               is_sgn, is_div, sa, sb, b_zero, early, last;
    logic [WIDTH-1:0]   abs_a, abs_b, rem_n, quo_n, fix_hi_in, fix_lo_in, fix_hi, fix_lo;
    logic [WIDTH:0]     sh, trial;
    assign is_sgn = (op == OP_MULT) || (op == OP_DIV);
    assign is_div = (op == OP_DIVU) || (op == OP_DIV);
    assign sa     = is_sgn & a[WIDTH-1];
    assign sb     = is_sgn & b[WIDTH-1];
    assign abs_a  = sa ? -a : a;
    assign abs_b  = sb ? -b : b;
    assign b_zero = b == '0;
    // Multiply: accumulate a left-shifting multiplicand under a right-shifting multiplier.
    assign acc_m = mp_q[0] ? acc_q + mc_q : acc_q;
    // Divide: restoring step; mp_q shifts the dividend out while quotient bits shift in.
    assign sh    = {acc_q[WIDTH-1:0], mp_q[WIDTH-1]};
    assign trial = sh - {1'b0, mc_q[WIDTH-1:0]};
    assign rem_n = trial[WIDTH] ? sh[WIDTH-1:0] : trial[WIDTH-1:0];
    assign quo_n = {mp_q[WIDTH-2:0], ~trial[WIDTH]};
`ifdef MDU_EARLY_TERM_EN
    assign early = !is_div_q && mp_q[WIDTH-1:1] == '0;
`else
    assign early = 1'b0;
`endif
    assign last      = bz_q || cnt_q == CNT_W'(WIDTH - 1) || early;
    assign fix_hi_in = is_div_q ? (bz_q ? mp_q : rem_n) : acc_m[2*WIDTH-1:WIDTH];
    assign fix_lo_in = is_div_q ? quo_n : acc_m[WIDTH-1:0];
    mdu_sign_fix #(.WIDTH(WIDTH)) u_fix (
        .is_div_i (is_div_q),
        .neg_pq_i (sgn_p_q),
        .neg_r_i  (sgn_r_q),
        .hi_i     (fix_hi_in),
        .lo_i     (fix_lo_in),
        .hi_o     (fix_hi),
        .lo_o     (fix_lo)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            mc_q     <= '0;
            mp_q     <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            is_div_q <= 1'b0;
            sgn_p_q  <= 1'b0;
            sgn_r_q  <= 1'b0;
            bz_q     <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mc_q     <= mc_d;
            mp_q     <= mp_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            is_div_q <= is_div_d;
            sgn_p_q  <= sgn_p_d;
            sgn_r_q  <= sgn_r_d;
            bz_q     <= bz_d;
            dz_q     <= dz_d;
        end
    end
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mc_d     = mc_q;
        mp_d     = mp_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        is_div_d = is_div_q;
        sgn_p_d  = sgn_p_q;
        sgn_r_d  = sgn_r_q;
        bz_d     = bz_q;
        dz_d     = dz_q;
        case (state_q)
            S_IDLE: if (start) begin
                state_d  = S_CALC;
                cnt_d    = '0;
                acc_d    = '0;
                is_div_d = is_div;
                bz_d     = is_div && b_zero;
                sgn_p_d  = (sa ^ sb) && !(is_div && b_zero);
                sgn_r_d  = sa;
                dz_d     = 1'b0;
                mc_d     = {{WIDTH{1'b0}}, is_div ? abs_b : abs_a};
                mp_d     = is_div ? abs_a : abs_b;
            end
            S_CALC: begin
                cnt_d = cnt_q + 1'b1;
                acc_d = is_div_q ? {{WIDTH{1'b0}}, rem_n} : acc_m;
                mc_d  = is_div_q ? mc_q : mc_q << 1;
                mp_d  = is_div_q ? quo_n : mp_q >> 1;
                if (last) begin
                    state_d = S_DONE;
                    hi_d    = fix_hi;
                    lo_d    = bz_q ? '1 : fix_lo;
                    dz_d    = bz_q;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end
    assign busy        = state_q == S_CALC;
    assign done        = state_q == S_DONE;
    assign hi          = hi_q;
    assign lo          = lo_q;
    assign div_by_zero = dz_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed and random checks of mult_div_unit against an arithmetic reference model.
module tb_mult_div_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = '0, b = '0;
    logic        busy, done, div_by_zero;
    logic [31:0] hi, lo;
    int          total = 0, bad = 0;
    logic [31:0] hi_prev = '0, lo_prev = '0;

    mult_div_unit dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Expected {hi,lo}, div_by_zero and cycles from start sample to done.
    task automatic model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         output logic [63:0] e, output logic ez, output int n);
        longint sx, sy, q, r, m;
        sx = o[0] ? longint'($signed(x)) : longint'(x);
        sy = o[0] ? longint'($signed(y)) : longint'(y);
        ez = 1'b0;
        n  = 32;
        if (!o[1]) begin
            e = sx * sy;
`ifdef MDU_EARLY_TERM_EN
            m = sy < 0 ? -sy : sy;
            n = 1;
            for (int i = 0; i < 64; i++) if (m[i]) n = i + 1;
`endif
        end else if (y == 0) begin
            e  = {x, 32'hFFFF_FFFF};
            ez = 1'b1;
            n  = 1;
        end else begin
            q = sx / sy;
            r = sx % sy;
            e = {r[31:0], q[31:0]};
        end
    endtask

    task automatic run(input string tag, input logic [1:0] o, input logic [31:0] x,
                       input logic [31:0] y, input int poke, input bit poke_done);
        logic [63:0] e;
        logic        ez, stable;
        int          n, k;
        model(o, x, y, e, ez, n);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0; op = 2'($urandom); a = $urandom; b = $urandom;
        k = 0;
        stable = 1'b1;
        while (!done && k < 40) begin
            if (hi !== hi_prev || lo !== lo_prev || busy !== 1'b1) stable = 1'b0;
            if (k == poke && poke < n) begin
                start = 1'b1; a = 32'd9; b = 32'd9;
            end
            @(posedge clk); #1;
            start = 1'b0;
            k++;
        end
        chk({tag, "_latency"}, 64'(k), 64'(n));
        chk({tag, "_stable"}, 64'(stable), 64'd1);
        chk({tag, "_result"}, {hi, lo}, e);
        chk({tag, "_dz"}, 64'(div_by_zero), 64'(ez));
        chk({tag, "_busy_at_done"}, 64'(busy), 64'd0);
        hi_prev = e[63:32];
        lo_prev = e[31:0];
        if (poke_done) begin
            start = 1'b1; a = 32'd9; b = 32'd9;
        end
        @(posedge clk); #1;
        start = 1'b0;
        if (poke_done) chk({tag, "_start_in_done_ignored"}, {62'd0, busy, done}, 64'd0);
    endtask

    initial begin
        logic        never_done;
        logic [31:0] x, y;
        logic [1:0]  o;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", {busy, done, div_by_zero, hi, lo}, '0);
        rst = 1'b0;
        run("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, 1'b0);
        run("mult_neg3x5", 2'b01, 32'hFFFF_FFFD, 32'd5, -1, 1'b0);
        run("multu_neg3x5", 2'b00, 32'hFFFF_FFFD, 32'd5, -1, 1'b0);
        run("divu_100_7", 2'b10, 32'd100, 32'd7, -1, 1'b0);
        run("div_neg7_2", 2'b11, 32'hFFFF_FFF9, 32'd2, -1, 1'b0);
        run("div_ovf", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, -1, 1'b0);
        run("div_by_zero", 2'b11, 32'h0000_1234, 32'd0, -1, 1'b0);
        run("dz_clear", 2'b00, 32'd2, 32'd3, -1, 1'b0);
        run("div_neg_by_zero", 2'b11, 32'h8000_0005, 32'd0, -1, 1'b0);
        run("ignore_start", 2'b00, 32'd2, 32'd3, 5, 1'b1);
        run("multu_7x5", 2'b00, 32'd7, 32'd5, -1, 1'b0);
        run("mult_neg_b", 2'b01, 32'd1000, 32'hFFFF_FFF0, -1, 1'b0);
        // Abort a divide mid-way with reset.
        @(negedge clk);
        start = 1'b1; op = 2'b10; a = 32'd100; b = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_outputs", {busy, done, div_by_zero, hi, lo}, '0);
        never_done = 1'b1;
        repeat (40) begin
            @(posedge clk); #1;
            if (done || busy) never_done = 1'b0;
        end
        chk("abort_no_done", 64'(never_done), 64'd1);
        hi_prev = '0;
        lo_prev = '0;
        for (int i = 0; i < 40; i++) begin
            o = 2'($urandom_range(0, 3));
            x = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 7))
                0: y = 32'd0;
                1: y = $urandom_range(0, 20);
                2: y = 32'hFFFF_FFFF;
                default: y = $urandom;
            endcase
            run($sformatf("rand%0d", i), o, x, y, -1, 1'b0);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
